// File: rtl/oem_merge_pipe.sv
// Two-half Batcher odd-even merge: each half is buffered in its own holding register,
// then both are merged through one registered comparator level per stage with ready/valid backpressure.
module oem_merge_pipe #(
    parameter int WIDTH = 3,
    parameter int n     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [n*WIDTH-1:0]       ina,
    input  logic                     ina_valid,
    output logic                     ina_ready,
    input  logic [n*WIDTH-1:0]       inb,
    input  logic                     inb_valid,
    output logic                     inb_ready,
    input  logic                     desc,
    output logic [2*n*WIDTH-1:0]     c,
    output logic                     c_valid,
    input  logic                     c_ready,
    output logic                     busy
);
    localparam int S  = $clog2(2 * n);
    localparam int DW = 2 * n * WIDTH;

    typedef enum logic [1:0] {EMPTY, HAVE_A, HAVE_B, BOTH} state_t;

    state_t             state, state_nxt;
    logic [n*WIDTH-1:0] a_buf, b_buf;
    logic               a_full, b_full, acc_a, acc_b, launch;
    logic [S-1:0]       vld_p, adv, vld_src, desc_src;
    logic [S-2:0]       desc_p;
    logic [DW-1:0]      data_p [S];
    logic [DW-1:0]      data_src [S];

    // One comparator level; level 0 pairs i with i+n, later levels pair within strides of n>>lvl.
    function automatic logic [DW-1:0] merge_level(input logic [DW-1:0] d, input logic dsc,
                                                  input int lvl);
        logic [DW-1:0]    r;
        logic [WIDTH-1:0] x, y;
        logic             hit;
        int               k;
        r = d;
        k = n >> lvl;
        for (int e = 0; e < 2 * n; e++) begin
            if (lvl == 0)
                hit = (e < n);
            else
                hit = (e >= k) && (((e - k) % (2 * k)) < k) && (e + k < 2 * n);
            if (hit) begin
                x = r[e*WIDTH +: WIDTH];
                y = r[(e+k)*WIDTH +: WIDTH];
                if (dsc ? (x < y) : (x > y)) begin
                    r[e*WIDTH +: WIDTH]     = y;
                    r[(e+k)*WIDTH +: WIDTH] = x;
                end
            end
        end
        return r;
    endfunction

    // Stage k can move when any stage from k to the output is empty or the sink takes data.
    for (genvar g = 0; g < S; g++) begin : g_adv
        assign adv[g] = c_ready || !(&vld_p[S-1:g]);
    end

    always_comb begin
        a_full    = (state == HAVE_A) || (state == BOTH);
        b_full    = (state == HAVE_B) || (state == BOTH);
        launch    = !rst && (state == BOTH) && adv[0];
        ina_ready = !rst && (!a_full || launch);
        inb_ready = !rst && (!b_full || launch);
        acc_a     = ina_valid && ina_ready;
        acc_b     = inb_valid && inb_ready;
        state_nxt = state;
        case (state)
            EMPTY: begin
                if (acc_a && acc_b) state_nxt = BOTH;
                else if (acc_a)     state_nxt = HAVE_A;
                else if (acc_b)     state_nxt = HAVE_B;
            end
            HAVE_A: if (acc_b) state_nxt = BOTH;
            HAVE_B: if (acc_a) state_nxt = BOTH;
            BOTH: begin
                if (launch) begin
                    if (acc_a && acc_b) state_nxt = BOTH;
                    else if (acc_a)     state_nxt = HAVE_A;
                    else if (acc_b)     state_nxt = HAVE_B;
                    else                state_nxt = EMPTY;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= EMPTY;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (acc_a) a_buf <= ina;
        if (acc_b) b_buf <= inb;
    end

    assign vld_src  = {vld_p[S-2:0], launch};
    assign desc_src = {desc_p, desc};

    for (genvar g = 0; g < S; g++) begin : g_src
        if (g == 0) begin : g_first
            assign data_src[g] = {b_buf, a_buf};
        end else begin : g_rest
            assign data_src[g] = data_p[g-1];
        end
    end

    // Stage boundaries: stage k registers the output of comparator level k.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p <= '0;
        end else begin
            for (int k = 0; k < S; k++)
                if (adv[k]) vld_p[k] <= vld_src[k];
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < S; k++)
            if (adv[k]) data_p[k] <= merge_level(data_src[k], desc_src[k], k);
        for (int k = 0; k < S - 1; k++)
            if (adv[k]) desc_p[k] <= desc_src[k];
    end

    assign c       = data_p[S-1];
    assign c_valid = !rst && vld_p[S-1];
    assign busy    = !rst && (a_full || b_full || (|vld_p));

endmodule

// File: doc/oem_merge_pipe.md
OEM_MERGE_PIPE -- requirements
Module: oem_merge_pipe

Interface
REQ-001 Parameter WIDTH, default 3: bit width of one sort key.
REQ-002 Parameter n, default 32: elements per input half; power of two, 2..64; output carries 2n elements.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 Port ina, input, n*WIDTH: half A, element k at bits [(k+1)*WIDTH-1 : k*WIDTH].
REQ-006 Port ina_valid / ina_ready, input / output, 1 each: handshake for half A.
REQ-007 Port inb, input, n*WIDTH: half B, same packing as ina.
REQ-008 Port inb_valid / inb_ready, input / output, 1 each: handshake for half B.
REQ-009 Port desc, input, 1: sort order, 0 = ascending, 1 = descending; sampled at launch.
REQ-010 Port c, output, 2*n*WIDTH: merged result, element 0 in the lowest slot.
REQ-011 Port c_valid / c_ready, output / input, 1 each: output handshake.
REQ-012 Port busy, output, 1: high when any half buffer or pipeline stage holds data.

Function
REQ-013 Each input half SHALL arrive pre-sorted in the order selected by desc at launch; unsorted halves yield unspecified but deterministic output.
REQ-014 A half is accepted when its valid and ready are both high on a clock edge; it is stored in its own holding register (A_buf or B_buf) with a full flag.
REQ-015 The holding FSM SHALL have four states: EMPTY, HAVE_A, HAVE_B and BOTH. It SHALL move to HAVE_A or HAVE_B on a single accept, and to BOTH on the second accept or on a simultaneous accept of both halves.
REQ-016 Launch SHALL occur in the cycle the FSM is in BOTH and stage 0 can advance. Launch moves A_buf, B_buf and desc into stage 0 and returns the FSM to EMPTY.
REQ-017 ina_ready SHALL be high when A_buf is empty or a launch occurs this cycle; inb_ready follows the same rule for B_buf. A half may be reloaded in its launch cycle.
REQ-018 The merge SHALL be the Batcher odd-even merge of 2n elements with S = log2(2n) comparator levels and one register stage per level. The desc bit SHALL travel with its data.
REQ-019 Each comparator outputs (min, max) into (lower, upper) slots when desc=0 and swaps them when desc=1. Equal keys pass unchanged. Comparison is unsigned.
REQ-020 Latency from launch edge to c_valid SHALL be exactly S cycles with no stall (n=32: 6 cycles).
REQ-021 Stall rule: stage k advances when it is empty or stage k+1 advances. The last stage advances when c_valid=0 or c_ready=1. No data is lost or duplicated under any c_ready pattern.
REQ-022 With c_ready held high, the block SHALL sustain one merge per cycle after fill.
REQ-023 c SHALL hold stable while c_valid=1 and c_ready=0.
REQ-024 The design SHALL contain no combinational path from c_ready to ina_ready or inb_ready longer than the stage-advance chain. A single registered skid is permitted.

Reset
REQ-025 While rst=1: FSM to EMPTY; all full/valid flags clear; c_valid=0; busy=0; ina_ready=inb_ready=0.
REQ-026 After rst deasserts: ina_ready=inb_ready=1 on the following cycle; c contents are don't-care while c_valid=0.
REQ-027 Reset asserted mid-operation SHALL discard all buffered and in-flight merges, with no c_valid pulse afterwards for them.

Verification
REQ-028 n=4, WIDTH=3, desc=0, ina={0,2,4,6}, inb={1,3,5,7} accepted together, c_ready=1 -> c={0,1,2,3,4,5,6,7} with c_valid exactly 3 cycles after launch.
REQ-029 n=4, desc=1, ina={7,5,3,1}, inb={6,6,2,0}, inb accepted 2 cycles before ina -> FSM passes through HAVE_B, and c={7,6,6,5,3,2,1,0}.
REQ-030 Back-to-back: 8 merges with c_ready=1, both valids held high -> 8 consecutive c_valid cycles in input order; busy drops one cycle after the last output.
REQ-031 Backpressure: random c_ready at 30% duty over 50 merges -> scoreboard match; c stable while stalled; inputs backpressured once the pipeline and buffers are full.
REQ-032 Ties and extremes: all-zero half with all-seven half, and all-equal keys {3,3,3,3}/{3,3,3,3} -> correct sorted output, no lost elements.
REQ-033 Reset mid-flight: launch 2 merges, assert rst 1 cycle later -> no c_valid afterwards; ready high on the first cycle after rst deasserts.
